serial_nibble_assembler: RTL and testbench

//  Upstream feeder for the 4-bit D-flip-flop register stage: assembles a serial bit stream into WIDTH-bit words.

---
 rtl/serial_nibble_assembler_pkg.sv | 12 +
 rtl/serial_nibble_assembler_bit_counter.sv | 29 ++
 rtl/serial_nibble_assembler.sv | 107 ++++++++++
 tb/tb_serial_nibble_assembler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_nibble_assembler_pkg.sv
// Shared definitions for the serial nibble assembler: FSM state encoding and default word width.
package serial_nibble_assembler_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_nibble_assembler_bit_counter.sv
// Mod-WIDTH bit counter, falling-edge clocked; done flags the increment that completes a word.
module serial_nibble_assembler_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic inc,
    input  logic clr,
    output logic done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [CW-1:0] count_q;

    // clr has priority so the completing increment returns the count to 0 instead of overflowing.
    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign done = inc && (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_nibble_assembler.sv
// Assembles a serial bit stream into WIDTH-bit words and offers them downstream with valid/ready.
module serial_nibble_assembler
    import serial_nibble_assembler_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             word_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             busy,
    output logic             overrun,
    output logic [1:0]       state_dbg
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word_q;
    logic             ovr_q;
    logic             inc;
    logic             cnt_clr;
    logic             done;

    assign inc     = (state_q == ST_SHIFT) && sin_valid;
    assign cnt_clr = (state_q != ST_SHIFT) || done;

    serial_nibble_assembler_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .clr_n (clr_n),
        .inc   (inc),
        .clr   (cnt_clr),
        .done  (done)
    );

    always_comb begin
        shifted = shift_q;
        if (MSB_FIRST != 0) begin
            shifted = {shift_q[WIDTH-2:0], sin};
        end else begin
            shifted = {sin, shift_q[WIDTH-1:1]};
        end
    end

    // Handshake: word_valid is high exactly in HOLD with word_out frozen; a word transfers on the
    // falling edge where word_valid && word_ready, and word_valid drops on that same edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (done) state_d = ST_HOLD;
            ST_HOLD:  if (word_ready) state_d = start ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The shift register is held clear outside SHIFT, so every word starts from zero.
    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            shift_q <= '0;
            word_q  <= '0;
        end else begin
            if (state_q != ST_SHIFT) begin
                shift_q <= '0;
            end else if (sin_valid) begin
                shift_q <= shifted;
            end
            if (done) begin
                word_q <= shifted;
            end
        end
    end

    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ovr_q <= 1'b0;
        end else if ((state_q == ST_HOLD) && sin_valid) begin
            ovr_q <= 1'b1;
        end else if (clr_ovr) begin
            ovr_q <= 1'b0;
        end
    end

    assign word_out   = word_q;
    assign word_valid = (state_q == ST_HOLD);
    assign busy       = (state_q != ST_IDLE);
    assign overrun    = ovr_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_serial_nibble_assembler.sv
// Bench for serial_nibble_assembler: MSB-first and LSB-first instances share one stimulus stream.
module tb_serial_nibble_assembler;

    localparam int W = 4;

    logic         clk = 1'b1;
    logic         clr_n = 1'b1;
    logic         start = 1'b0;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         word_ready = 1'b0;
    logic         clr_ovr = 1'b0;

    logic [W-1:0] m_word_out;
    logic         m_word_valid;
    logic         m_busy;
    logic         m_overrun;
    logic [1:0]   m_state;
    logic [W-1:0] l_word_out;
    logic         l_word_valid;
    logic         l_busy;
    logic         l_overrun;
    logic [1:0]   l_state;

    int total = 0;
    int bad = 0;
    bit en = 1'b0;

    // model of the specified behaviour
    bit           md_collect = 1'b0;
    bit           md_hold = 1'b0;
    bit           md_ovr = 1'b0;
    logic [W-1:0] md_msb = '0;
    logic [W-1:0] md_lsb = '0;
    logic         bits_q[$];
    logic [W-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    serial_nibble_assembler #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .clr_n(clr_n), .start(start), .sin(sin), .sin_valid(sin_valid),
        .word_ready(word_ready), .clr_ovr(clr_ovr), .word_out(m_word_out),
        .word_valid(m_word_valid), .busy(m_busy), .overrun(m_overrun), .state_dbg(m_state)
    );

    serial_nibble_assembler #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .clr_n(clr_n), .start(start), .sin(sin), .sin_valid(sin_valid),
        .word_ready(word_ready), .clr_ovr(clr_ovr), .word_out(l_word_out),
        .word_valid(l_word_valid), .busy(l_busy), .overrun(l_overrun), .state_dbg(l_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            md_collect = 1'b0;
            md_hold    = 1'b0;
            md_ovr     = 1'b0;
            md_msb     = '0;
            md_lsb     = '0;
            bits_q.delete();
            exp_q.delete();
        end else begin
            if (md_hold && sin_valid) md_ovr = 1'b1;
            else if (clr_ovr) md_ovr = 1'b0;
            if (md_hold) begin
                if (word_ready) begin
                    md_hold    = 1'b0;
                    md_collect = start;
                    bits_q.delete();
                end
            end else if (md_collect) begin
                if (sin_valid) begin
                    bits_q.push_back(sin);
                    if (bits_q.size() == W) begin
                        int acc_m;
                        int acc_l;
                        acc_m = 0;
                        acc_l = 0;
                        for (int i = 0; i < W; i++) begin
                            acc_m = acc_m * 2 + int'(bits_q[i]);
                            acc_l = acc_l + (int'(bits_q[i]) << i);
                        end
                        md_msb = acc_m[W-1:0];
                        md_lsb = acc_l[W-1:0];
                        exp_q.push_back(md_msb);
                        md_hold    = 1'b1;
                        md_collect = 1'b0;
                        bits_q.delete();
                    end
                end
            end else if (start) begin
                md_collect = 1'b1;
                bits_q.delete();
            end
        end
    end

    // scoreboard: outputs are stable between falling edges, so compare on the rising edge
    always @(posedge clk) begin
        if (en) begin
            check("m_word_valid", m_word_valid, md_hold);
            check("m_busy", m_busy, md_collect | md_hold);
            check("m_overrun", m_overrun, md_ovr);
            check("m_word_out", m_word_out, md_msb);
            check("l_word_valid", l_word_valid, md_hold);
            check("l_busy", l_busy, md_collect | md_hold);
            check("l_overrun", l_overrun, md_ovr);
            check("l_word_out", l_word_out, md_lsb);
            if (m_word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    check("handshake_without_expected_word", 1, 0);
                end else begin
                    check("handshake_word", m_word_out, exp_q.pop_front());
                end
            end
        end
    end

    // driver tasks: inputs change just after a falling edge and are consumed at the next one
    task automatic step(input logic st, input logic sv, input logic sb, input logic rdy, input logic co);
        start      = st;
        sin_valid  = sv;
        sin        = sb;
        word_ready = rdy;
        clr_ovr    = co;
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        step(1'b0, 1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic handshake();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] bits);
        for (int i = W - 1; i >= 0; i--) send(bits[i]);
    endtask

    initial begin
        logic [W-1:0] gap_bits;

        #2 clr_n = 1'b0;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        clr_n = 1'b1;
        check("rst_word_out", m_word_out, 0);
        check("rst_word_valid", m_word_valid, 0);
        check("rst_busy", m_busy, 0);
        check("rst_overrun", m_overrun, 0);
        check("rst_state", m_state, 0);
        en = 1'b1;

        // reset asserted between edges clears a held word and overrun immediately
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(4'b1111);
        check("t1_full_valid", m_word_valid, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_overrun_set", m_overrun, 1);
        start = 1'b0; sin_valid = 1'b0; sin = 1'b0; word_ready = 1'b0; clr_ovr = 1'b0;
        #1 clr_n = 1'b0;
        #1;
        check("t1_async_word_out", m_word_out, 0);
        check("t1_async_valid", m_word_valid, 0);
        check("t1_async_busy", m_busy, 0);
        check("t1_async_overrun", m_overrun, 0);
        #4 clr_n = 1'b1;
        @(negedge clk);
        #1;
        check("t1_release_busy", m_busy, 0);
        check("t1_release_state", m_state, 0);

        // word_ready outside HOLD has no effect
        handshake();
        check("idle_ready_busy", m_busy, 0);

        // MSB-first word 1011 on consecutive edges
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_state_shift", m_state, 1);
        send(1'b1);
        send(1'b0);
        send(1'b1);
        check("t2_not_yet_valid", m_word_valid, 0);
        send(1'b1);
        check("t2_word", m_word_out, 4'b1011);
        check("t2_valid", m_word_valid, 1);
        check("t2_state_hold", m_state, 2);
        handshake();
        check("t2_valid_drop", m_word_valid, 0);
        check("t2_busy_drop", m_busy, 0);
        check("t2_word_retained", m_word_out, 4'b1011);

        // gaps of two idle cycles between bits
        gap_bits = 4'b0110;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = W - 1; i >= 0; i--) begin
            send(gap_bits[i]);
            if (i > 0) begin
                idle();
                idle();
                check("t3_gap_valid", m_word_valid, 0);
            end
        end
        check("t3_word", m_word_out, 4'b0110);
        check("t3_valid", m_word_valid, 1);
        handshake();

        // backpressure, overrun, clear; set wins over clear
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(4'b1011);
        idle();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        check("t4_word_frozen", m_word_out, 4'b1011);
        check("t4_overrun", m_overrun, 1);
        check("t4_still_valid", m_word_valid, 1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("t4_set_wins", m_overrun, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_clr_ovr", m_overrun, 0);
        check("t4_word_after_clr", m_word_out, 4'b1011);

        // back-to-back: handshake and start on the same edge
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_busy_kept", m_busy, 1);
        check("t5_valid_drop", m_word_valid, 0);
        check("t5_state_shift", m_state, 1);
        send_word(4'b0001);
        check("t5_word", m_word_out, 4'b0001);
        check("t5_lsb_word", l_word_out, 4'b1000);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t5_ovr_on_handshake", m_overrun, 1);
        check("t5_idle_after", m_busy, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_ovr_cleared", m_overrun, 0);

        // reset mid-word discards partial bits
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b1);
        send(1'b0);
        start = 1'b0; sin_valid = 1'b0; sin = 1'b0;
        #1 clr_n = 1'b0;
        #1;
        check("t6_async_busy", m_busy, 0);
        #1 clr_n = 1'b1;
        @(negedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(4'b1100);
        check("t6_clean_word", m_word_out, 4'b1100);
        check("t6_clean_lsb", l_word_out, 4'b0011);
        handshake();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(4'b1011);
        check("t6_msb_word", m_word_out, 4'b1011);
        check("t6_lsb_word", l_word_out, 4'b1101);
        check("t6_lsb_valid", l_word_valid, 1);
        handshake();
        check("t6_lsb_retained", l_word_out, 4'b1101);

        idle();
        idle();
        check("words_all_delivered", exp_q.size(), 0);
        en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
